// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers h/v pixel counters from incoming active-low hsync/vsync, checks timing, tracks lock.
// Latency: haddress/vaddress lag the transmitting generator's counters by exactly one clock.
// No backpressure: free-running pixel stream. Optional flywheel on missing hsync via VGA_SYNC_DEC_FLYWHEEL_EN.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_ACT_START = 35,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_LIMIT  = 3
) (
  input  logic        clk_25Mhz,
  input  logic        rst,
  input  logic        hsynq,
  input  logic        vsynq,
  output logic [15:0] haddress,
  output logic [15:0] vaddress,
  output logic        de,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_error
);

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] HS_LAST  = 16'(H_SYNC - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] VS_LAST  = 16'(V_SYNC - 1);
  localparam logic [16:0] H_ACT_LO = 17'(H_ACT_START);
  localparam logic [16:0] H_ACT_HI = 17'(H_ACT_START + H_ACT);
  localparam logic [16:0] V_ACT_LO = 17'(V_ACT_START);
  localparam logic [16:0] V_ACT_HI = 17'(V_ACT_START + V_ACT);
  localparam logic [15:0] LOCK_N   = 16'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        hs_r_q, vs_r_q;
  logic [15:0] haddress_q, haddress_d;
  logic [15:0] vaddress_q, vaddress_d;
  logic        de_q, de_d;
  logic        frame_start_q, frame_start_d;
  logic        sync_error_q, sync_error_d;
  logic [15:0] gcnt_q, gcnt_d, gcnt_inc;
  logic        first_q, first_d;

  logic hs_fall, hs_rise, vs_fall, vs_rise;
  logic h_last, v_last, h_reload, miss_h, miss_v;
  logic e_hfall, e_hrise, e_vnoh, e_vfall, e_vrise;
  logic err_other, any_err, fly_hold;
  logic h_in, v_in;

  // Edge detection against the previous-cycle samples.
  assign hs_fall = hs_r_q & ~hsynq;
  assign hs_rise = ~hs_r_q & hsynq;
  assign vs_fall = vs_r_q & ~vsynq;
  assign vs_rise = ~vs_r_q & vsynq;

  assign h_last   = (haddress_q == H_LAST);
  assign v_last   = (vaddress_q == V_LAST);
  // A wrap coinciding with hs_fall is a normal line end, not a miss.
  assign miss_h   = h_last & ~hs_fall;
  assign h_reload = hs_fall | h_last;

  // Recovered counters: hsync reloads, otherwise free-run and wrap at line/frame end.
  always_comb begin
    haddress_d    = haddress_q + 16'd1;
    vaddress_d    = vaddress_q;
    frame_start_d = 1'b0;
    miss_v        = 1'b0;
    if (h_reload) begin
      haddress_d = '0;
      if (vs_fall) begin
        vaddress_d    = '0;
        frame_start_d = 1'b1;
      end else if (v_last) begin
        vaddress_d    = '0;
        frame_start_d = 1'b1;
        miss_v        = 1'b1;
      end else begin
        vaddress_d = vaddress_q + 16'd1;
      end
    end
  end

  // Timing checks; the first hs_fall after entering ACQUIRE is exempt from the line-length check.
  assign e_hfall   = hs_fall & ~h_last & ~first_q;
  assign e_hrise   = hs_rise & (haddress_q != HS_LAST);
  assign e_vnoh    = vs_fall & ~hs_fall;
  assign e_vfall   = vs_fall & ~v_last;
  assign e_vrise   = vs_rise & (vaddress_q != VS_LAST);
  assign err_other = e_hfall | e_hrise | e_vnoh | e_vfall | e_vrise | miss_v;
  assign any_err   = err_other | miss_h;

`ifdef VGA_SYNC_DEC_FLYWHEEL_EN
  localparam logic [15:0] MISS_N = 16'(MISS_LIMIT);
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Lock survives up to MISS_N consecutive missing hsyncs when nothing else is wrong.
  assign fly_hold = (state_q == ST_LOCKED) & miss_h & ~err_other & (miss_cnt_q < MISS_N);

  // Consecutive-miss count: any real hs_fall, or not being locked, clears it.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (hs_fall || (state_q != ST_LOCKED)) begin
      miss_cnt_d = '0;
    end else if (miss_h) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  // Miss counter register.
  always_ff @(posedge clk_25Mhz) begin
    if (rst) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end
`else
  // Without the flywheel a missing hsync is never tolerated (MISS_LIMIT is never negative).
  assign fly_hold = miss_h & (MISS_LIMIT < 0);
`endif

  // Lock FSM state register.
  always_ff @(posedge clk_25Mhz) begin
    if (rst) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign gcnt_inc = gcnt_q + 16'd1;

  // Lock FSM next state and clean-frame counting.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ST_SEARCH: begin
        gcnt_d = '0;
        if (vs_fall && hs_fall) begin
          state_d = ST_ACQUIRE;
        end
      end
      ST_ACQUIRE: begin
        if (any_err) begin
          state_d = ST_SEARCH;
        end else if (vs_fall) begin
          gcnt_d = gcnt_inc;
          if (gcnt_inc >= LOCK_N) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (any_err && !fly_hold) begin
          state_d = ST_SEARCH;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Lock FSM outputs: error pulses are suppressed while searching.
  always_comb begin
    locked       = (state_q == ST_LOCKED);
    sync_error_d = any_err & (state_q != ST_SEARCH);
  end

  // Exemption flag armed on entry to ACQUIRE, consumed by the next hs_fall.
  always_comb begin
    if (state_q == ST_SEARCH) begin
      first_d = (state_d == ST_ACQUIRE);
    end else begin
      first_d = first_q & ~hs_fall;
    end
  end

  // Visible window evaluated on next-state values so de lines up with the counters.
  assign h_in = ({1'b0, haddress_d} >= H_ACT_LO) & ({1'b0, haddress_d} < H_ACT_HI);
  assign v_in = ({1'b0, vaddress_d} >= V_ACT_LO) & ({1'b0, vaddress_d} < V_ACT_HI);
  assign de_d = (state_d == ST_LOCKED) & h_in & v_in;

  // Datapath registers; sync samples reset high so release never looks like an edge.
  always_ff @(posedge clk_25Mhz) begin
    if (rst) begin
      hs_r_q        <= 1'b1;
      vs_r_q        <= 1'b1;
      haddress_q    <= '0;
      vaddress_q    <= '0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      sync_error_q  <= 1'b0;
      gcnt_q        <= '0;
      first_q       <= 1'b0;
    end else begin
      hs_r_q        <= hsynq;
      vs_r_q        <= vsynq;
      haddress_q    <= haddress_d;
      vaddress_q    <= vaddress_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      sync_error_q  <= sync_error_d;
      gcnt_q        <= gcnt_d;
      first_q       <= first_d;
    end
  end

  assign haddress    = haddress_q;
  assign vaddress    = vaddress_q;
  assign de          = de_q;
  assign frame_start = frame_start_q;
  assign sync_error  = sync_error_q;

endmodule
